// File: rtl/alu_rs_scheduler_if.sv
// Dispatch, CDB snoop, ALU drive and result-buffer signals of the ALU reservation station.
// The slave modport is the scheduler's view; master is the surrounding core's view.
interface alu_rs_scheduler_if #(
   parameter int TAG_W = 4,
   parameter int XLEN  = 32
);
   logic             flush;
   logic             disp_valid;
   logic             disp_ready;
   logic [3:0]       disp_op;
   logic [TAG_W-1:0] disp_dest;
   logic             disp_j_rdy;
   logic [XLEN-1:0]  disp_vj;
   logic [TAG_W-1:0] disp_qj;
   logic             disp_k_rdy;
   logic [XLEN-1:0]  disp_vk;
   logic [TAG_W-1:0] disp_qk;
   logic             cdb_valid;
   logic [TAG_W-1:0] cdb_tag;
   logic [XLEN-1:0]  cdb_data;
   logic [XLEN-1:0]  alu_a;
   logic [XLEN-1:0]  alu_b;
   logic [3:0]       alu_op;
   logic [XLEN-1:0]  alu_result;
   logic             res_valid;
   logic             res_ready;
   logic [TAG_W-1:0] res_tag;
   logic [XLEN-1:0]  res_data;
   logic             busy;

   modport slave (
      input  flush, disp_valid, disp_op, disp_dest,
      input  disp_j_rdy, disp_vj, disp_qj, disp_k_rdy, disp_vk, disp_qk,
      input  cdb_valid, cdb_tag, cdb_data, alu_result, res_ready,
      output disp_ready, alu_a, alu_b, alu_op, res_valid, res_tag, res_data, busy
   );

   modport master (
      output flush, disp_valid, disp_op, disp_dest,
      output disp_j_rdy, disp_vj, disp_qj, disp_k_rdy, disp_vk, disp_qk,
      output cdb_valid, cdb_tag, cdb_data, alu_result, res_ready,
      input  disp_ready, alu_a, alu_b, alu_op, res_valid, res_tag, res_data, busy
   );
endinterface

// File: rtl/alu_rs_scheduler.sv
// Reservation station and round-robin issue scheduler for the shared integer ALU,
// with CDB tag snooping and a one-deep handshaked result buffer.
module alu_rs_scheduler #(
   parameter int NUM_ENTRIES = 4,
   parameter int TAG_W       = 4,
   parameter int XLEN        = 32
) (
   input logic               clk,
   input logic               rst,
   alu_rs_scheduler_if.slave rs
);
   localparam int IDX_W = $clog2(NUM_ENTRIES);
   localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

   logic [NUM_ENTRIES-1:0] valid_r;
   logic [NUM_ENTRIES-1:0] j_rdy_r;
   logic [NUM_ENTRIES-1:0] k_rdy_r;
   logic [3:0]             op_r   [NUM_ENTRIES];
   logic [TAG_W-1:0]       dest_r [NUM_ENTRIES];
   logic [TAG_W-1:0]       qj_r   [NUM_ENTRIES];
   logic [TAG_W-1:0]       qk_r   [NUM_ENTRIES];
   logic [XLEN-1:0]        vj_r   [NUM_ENTRIES];
   logic [XLEN-1:0]        vk_r   [NUM_ENTRIES];
   logic [IDX_W-1:0]       rr_ptr_r;
   logic                   res_valid_r;
   logic [TAG_W-1:0]       res_tag_r;
   logic [XLEN-1:0]        res_data_r;

   logic [NUM_ENTRIES-1:0] ready_s;
   logic                   disp_ready_s;
   logic                   can_issue_s;
   logic                   found_s;
   logic                   hit_s;
   logic                   issue_s;
   logic [IDX_W-1:0]       cand_s;
   logic [IDX_W-1:0]       win_s;
   logic                   alloc_s;
   logic [IDX_W-1:0]       alloc_idx_s;
   logic                   alloc_j_hit_s;
   logic                   alloc_k_hit_s;

   // Readiness uses registered operand state only, so a CDB capture never bypasses into issue.
   assign ready_s      = valid_r & j_rdy_r & k_rdy_r;
   assign disp_ready_s = ~(&valid_r);
   assign can_issue_s  = !res_valid_r || rs.res_ready;

   assign rs.disp_ready = disp_ready_s;
   assign rs.res_valid  = res_valid_r;
   assign rs.res_tag    = res_tag_r;
   assign rs.res_data   = res_data_r;
   assign rs.busy       = (|valid_r) || res_valid_r;

   // Round-robin select: first ready entry at or after rr_ptr, wrapping.
   always_comb begin
      found_s = 1'b0;
      win_s   = '0;
      cand_s  = '0;
      hit_s   = 1'b0;
      for (int off = 0; off < NUM_ENTRIES; off++) begin
         cand_s  = rr_ptr_r + IDX_W'(off);
         hit_s   = !found_s && ready_s[cand_s];
         win_s   = hit_s ? cand_s : win_s;
         found_s = found_s || hit_s;
      end
      issue_s = found_s && can_issue_s;
   end

   // Lowest free slot and same-cycle CDB capture for the incoming op.
   always_comb begin
      alloc_idx_s = '0;
      for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
         alloc_idx_s = valid_r[i] ? alloc_idx_s : IDX_W'(i);
      end
      alloc_s       = rs.disp_valid && disp_ready_s;
      alloc_j_hit_s = !rs.disp_j_rdy && rs.cdb_valid && (rs.cdb_tag == rs.disp_qj);
      alloc_k_hit_s = !rs.disp_k_rdy && rs.cdb_valid && (rs.cdb_tag == rs.disp_qk);
   end

   // Drive the shared ALU with the winning entry's operands, zeros when idle.
   always_comb begin
      if (issue_s) begin
         rs.alu_a  = vj_r[win_s];
         rs.alu_b  = vk_r[win_s];
         rs.alu_op = op_r[win_s];
      end else begin
         rs.alu_a  = '0;
         rs.alu_b  = '0;
         rs.alu_op = 4'd0;
      end
   end

   // Entry table, round-robin pointer and result buffer; flush keeps rr_ptr.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_r     <= '0;
         j_rdy_r     <= '0;
         k_rdy_r     <= '0;
         rr_ptr_r    <= '0;
         res_valid_r <= 1'b0;
         res_tag_r   <= '0;
         res_data_r  <= '0;
      end else if (rs.flush) begin
         valid_r     <= '0;
         res_valid_r <= 1'b0;
         res_tag_r   <= '0;
         res_data_r  <= '0;
      end else begin
         for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (valid_r[i] && !j_rdy_r[i] && rs.cdb_valid && (rs.cdb_tag == qj_r[i])) begin
               j_rdy_r[i] <= 1'b1;
               vj_r[i]    <= rs.cdb_data;
            end
            if (valid_r[i] && !k_rdy_r[i] && rs.cdb_valid && (rs.cdb_tag == qk_r[i])) begin
               k_rdy_r[i] <= 1'b1;
               vk_r[i]    <= rs.cdb_data;
            end
         end
         // Issue and drain in the same cycle simply reloads the buffer.
         if (issue_s) begin
            valid_r[win_s] <= 1'b0;
            rr_ptr_r       <= win_s + IDX_ONE;
            res_valid_r    <= 1'b1;
            res_tag_r      <= dest_r[win_s];
            res_data_r     <= rs.alu_result;
         end else if (res_valid_r && rs.res_ready) begin
            res_valid_r <= 1'b0;
         end
         if (alloc_s) begin
            valid_r[alloc_idx_s] <= 1'b1;
            op_r[alloc_idx_s]    <= rs.disp_op;
            dest_r[alloc_idx_s]  <= rs.disp_dest;
            qj_r[alloc_idx_s]    <= rs.disp_qj;
            qk_r[alloc_idx_s]    <= rs.disp_qk;
            j_rdy_r[alloc_idx_s] <= rs.disp_j_rdy || alloc_j_hit_s;
            k_rdy_r[alloc_idx_s] <= rs.disp_k_rdy || alloc_k_hit_s;
            vj_r[alloc_idx_s]    <= alloc_j_hit_s ? rs.cdb_data : rs.disp_vj;
            vk_r[alloc_idx_s]    <= alloc_k_hit_s ? rs.cdb_data : rs.disp_vk;
         end
      end
   end
endmodule

// File: doc/alu_rs_scheduler.md
Name: alu_rs_scheduler

Overview:
- Reservation station plus issue scheduler for the single shared integer ALU in the Tomasulo core.
- Accepts renamed ALU ops from dispatch and holds them in NUM_ENTRIES slots.
- Snoops the CDB for pending source tags, picks one ready entry per cycle round-robin, and drives the combinational ALU.
- Registers the result into a one-deep output buffer that is handshaked onto the CDB.

Parameters:
NUM_ENTRIES, 4, reservation-station slots (power of 2, >=2)
TAG_W, 4, ROB/physical tag width
XLEN, 32, data width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
flush  in  1  squash all entries and output buffer (mispredict)
disp_valid  in  1  dispatch offers an op
disp_ready  out  1  a free slot exists
disp_op  in  4  ALU opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SLT
disp_dest  in  TAG_W  destination tag
disp_j_rdy  in  1  operand j value valid
disp_vj  in  XLEN  operand j value
disp_qj  in  TAG_W  operand j producer tag
disp_k_rdy, disp_vk, disp_qk  in  1/XLEN/TAG_W  same for operand k
cdb_valid  in  1  broadcast valid
cdb_tag  in  TAG_W  broadcast tag
cdb_data  in  XLEN  broadcast value
alu_a  out  XLEN  ALU operand a
alu_b  out  XLEN  ALU operand b
alu_op  out  4  ALU opcode
alu_result  in  XLEN  combinational ALU result
res_valid  out  1  result buffer full
res_ready  in  1  CDB grant
res_tag  out  TAG_W  result destination tag
res_data  out  XLEN  result value
busy  out  1  any entry or result buffer occupied

Behaviour:
- Reset (rst=1 at posedge): all entries invalid; rr_ptr=0; res_valid=0; res_tag=0; res_data=0.
- rst has priority over flush. flush has the same effect as reset, except rr_ptr is kept.
- A dispatch or issue in the same cycle as flush is discarded.
- disp_ready = any entry invalid, using current state only. A slot freed by issue becomes allocatable the next cycle.
- Allocation on disp_valid&&disp_ready:
  - Writes the lowest-index free entry.
  - If an operand is not ready and cdb_valid && cdb_tag == its q tag in the same cycle, the entry captures cdb_data and marks that operand ready.
- Snoop: every valid entry waiting on an operand captures cdb_data when cdb_valid && tag matches. Both operands may capture from one broadcast.
- An entry is ready when both operands are ready, evaluated on registered state. A value captured at edge t is issuable in cycle t+1; there is no same-cycle bypass into issue.
- can_issue = !res_valid || res_ready.
- Select:
  - Scan entries starting at rr_ptr, ascending mod NUM_ENTRIES; the first ready entry wins.
  - On issue, rr_ptr <= (winner+1) mod NUM_ENTRIES. With no issue, rr_ptr is held.
- Issue cycle:
  - alu_a=vj, alu_b=vk, alu_op=op of the winner.
  - At posedge: res_data <= alu_result, res_tag <= dest, res_valid <= 1, entry invalidated.
- When not issuing: alu_a=0, alu_b=0, alu_op=0.
- Output buffer: res_valid&&res_ready with no new issue clears res_valid to 0. A drain and an issue in the same cycle reloads the buffer, so res_valid stays 1. res_tag/res_data hold their values while stalled.
- Minimum latency: op dispatched with both operands ready at cycle t; issues at t+1; res_valid at t+2.
- Full: with NUM_ENTRIES occupied, disp_ready=0 even if an issue occurs that cycle.
- Dispatch and issue of different entries may occur in the same cycle. A just-dispatched entry is never issued in its allocation cycle.
- busy = any entry valid || res_valid.

Test Plan:
- Reset, then dispatch ADD vj=10 vk=20 dest=3 both ready at cycle 1, res_ready=1 -> alu_op=0 in cycle 2; res_valid=1, res_tag=3, res_data=30 in cycle 3; res_valid=0 in cycle 4.
- Dispatch SUB dest=5, j waiting on qj=7, vk=30 -> no issue. Then cdb_valid, tag=7, data=50 -> issue the next cycle; res_data=20.
- Dispatch with qj=2 while cdb_valid, tag=2, data=0xFF in the same cycle; op AND, vk=0x0F -> captures at allocation, issues next cycle, res_data=0x0F.
- Fill 4 ready entries with res_ready=0 -> disp_ready=0. One issue fills the buffer, then stall: res_valid stays 1, no further issue. Raise res_ready -> entries issue in order 1,2,3 after 0 (round-robin), one per cycle.
- Entries 0 and 2 ready, rr_ptr=1 -> entry 2 issues first, rr_ptr becomes 3, then entry 0 issues.
- 3 pending entries plus a full buffer; assert flush in the same cycle as disp_valid -> next cycle busy=0, res_valid=0, disp_ready=1, and the dispatched op is absent.
